// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the Wishbone RAM slave.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: transfer FSM state encoding and the default RAM depth (log2 words).
package wb_ram_pkg;

   localparam int DEPTH_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/wb_ram_array.sv
// Synchronous single-port RAM with per-byte write enables.
// Latency: 1 cycle registered read; write commits on the enabled clock edge.
// Backpressure: none, an access is taken on every enabled cycle.
//
// Ports:
//   clk   - rising-edge clock
//   en    - access enable; rdata only updates on enabled cycles
//   we    - write enable, qualified per lane by be
//   be    - byte lane enables
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (old content on a read-during-write)
module wb_ram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_W    = 8
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DEPTH_W-1:0]      addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   // Contents are deliberately not reset.
   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_W)-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < NB; b++) begin
               if (be[b]) begin
                  mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/wb_ram.sv
// Wishbone classic slave in front of a byte-writable single-port RAM.
// Latency: request sampled in IDLE cycle N, ACK/ERR and read data in cycle N+2.
// Backpressure: none; one transfer per 3 cycles, requests only taken in IDLE.
//
// Ports: clk, arst (async, active-low), S_ADR_I/S_DAT_I/S_WE_I/S_SEL_I request,
//   S_STB_I/S_CYC_I strobe and cycle, S_DAT_O read data (0 outside RESP),
//   S_ACK_O/S_ERR_O single-cycle registered acknowledge.
// Optional: define WB_RAM_ERR_EN to answer addresses outside the BASE_ADDR
//   window with S_ERR_O; otherwise addresses alias modulo the RAM depth.
module wb_ram
   import wb_ram_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH_W    = DEPTH_W_DEFAULT,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic [DATA_WIDTH-1:0]   S_DAT_I,
   input  logic [ADDR_WIDTH-1:0]   S_ADR_I,
   output logic [DATA_WIDTH-1:0]   S_DAT_O,
   input  logic                    S_WE_I,
   input  logic [DATA_WIDTH/8-1:0] S_SEL_I,
   input  logic                    S_STB_I,
   input  logic                    S_CYC_I,
   output logic                    S_ACK_O,
   output logic                    S_ERR_O
);

   localparam int NB = DATA_WIDTH / 8;

   state_t                state;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic                  we_q;
   logic [NB-1:0]         sel_q;
   logic                  ack_q;
   logic                  err_q;
   logic                  oor;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef WB_RAM_ERR_EN
   assign oor     = adr_q[ADDR_WIDTH-1:DEPTH_W+2] != BASE_ADDR[ADDR_WIDTH-1:DEPTH_W+2];
   assign S_ERR_O = err_q;
   logic unused_ok;
   assign unused_ok = ^adr_q[1:0];
`else
   assign oor     = 1'b0;
   assign S_ERR_O = 1'b0;
   logic unused_ok;
   assign unused_ok = ^{adr_q[1:0], adr_q[ADDR_WIDTH-1:DEPTH_W+2], BASE_ADDR, err_q};
`endif

   // Write lands on the MEM->RESP edge; a dropped CYC in MEM or an async
   // reset (state leaves MEM immediately) suppresses it.
   assign ram_we = (state == MEM) && S_CYC_I && we_q && !oor;

   // Read issued in MEM, so the registered RAM output is ready in RESP and
   // holds there because the RAM is not enabled again until the next MEM.
   wb_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_W    (DEPTH_W)
   ) u_array (
      .clk   (clk),
      .en    (state == MEM),
      .we    (ram_we),
      .be    (sel_q),
      .addr  (adr_q[DEPTH_W+1:2]),
      .wdata (dat_q),
      .rdata (ram_rdata)
   );

   assign S_DAT_O = ((state == RESP) && !oor) ? ram_rdata : '0;
   assign S_ACK_O = ack_q;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state <= IDLE;
         adr_q <= '0;
         dat_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (S_CYC_I && S_STB_I) begin
                  state <= MEM;
                  adr_q <= S_ADR_I;
                  dat_q <= S_DAT_I;
                  we_q  <= S_WE_I;
                  sel_q <= S_SEL_I;
               end
            end
            MEM: begin
               if (!S_CYC_I) begin
                  state <= IDLE;
               end else begin
                  state <= RESP;
                  ack_q <= !oor;
                  err_q <= oor;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ram.sv
// Self-checking bench for wb_ram: directed scenarios plus randomized traffic
// against a word-array reference model of the RAM.
module tb_wb_ram;

   logic        clk = 1'b0;
   logic        arst;
   logic [31:0] S_DAT_I, S_ADR_I, S_DAT_O;
   logic        S_WE_I;
   logic [3:0]  S_SEL_I;
   logic        S_STB_I, S_CYC_I, S_ACK_O, S_ERR_O;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   logic [31:0] model [256];
   bit          known [256];

`ifdef WB_RAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   wb_ram dut (
      .clk     (clk),
      .arst    (arst),
      .S_DAT_I (S_DAT_I),
      .S_ADR_I (S_ADR_I),
      .S_DAT_O (S_DAT_O),
      .S_WE_I  (S_WE_I),
      .S_SEL_I (S_SEL_I),
      .S_STB_I (S_STB_I),
      .S_CYC_I (S_CYC_I),
      .S_ACK_O (S_ACK_O),
      .S_ERR_O (S_ERR_O)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) check("ack_err_excl", 32'(S_ACK_O & S_ERR_O), 32'd0);
   end

   function automatic bit is_oor(input logic [31:0] a);
      return ERR_EN && (a[31:10] != 22'd0);
   endfunction

   task automatic idle_bus();
      S_CYC_I = 1'b0;
      S_STB_I = 1'b0;
      S_WE_I  = 1'b0;
      S_SEL_I = 4'h0;
      S_ADR_I = $urandom;
      S_DAT_I = $urandom;
   endtask

   task automatic drive_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
      S_CYC_I = 1'b1;
      S_STB_I = 1'b1;
      S_WE_I  = we;
      S_ADR_I = adr;
      S_DAT_I = dat;
      S_SEL_I = sel;
   endtask

   task automatic model_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      int idx;
      idx = int'(adr[9:2]);
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) model[idx][b*8 +: 8] = dat[b*8 +: 8];
      end
      if (sel == 4'hF) known[idx] = 1'b1;
   endtask

   // One full transfer; request inputs are scrambled after sampling to show
   // that the slave works from its latched copy.
   task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input string tag);
      int          idx;
      bit          oor;
      logic [31:0] old;
      bit          kn;
      idx = int'(adr[9:2]);
      oor = is_oor(adr);
      old = model[idx];
      kn  = known[idx];
      @(negedge clk);
      drive_req(we, adr, dat, sel);
      @(negedge clk);
      check({tag, "_mem_ack"}, 32'(S_ACK_O), 32'd0);
      check({tag, "_mem_err"}, 32'(S_ERR_O), 32'd0);
      S_STB_I = 1'b0;
      S_WE_I  = 1'($urandom);
      S_ADR_I = $urandom;
      S_DAT_I = $urandom;
      S_SEL_I = 4'($urandom);
      @(negedge clk);
      check({tag, "_ack"}, 32'(S_ACK_O), 32'(!oor));
      check({tag, "_err"}, 32'(S_ERR_O), 32'(oor));
      if (oor) check({tag, "_dat_oor"}, S_DAT_O, 32'd0);
      else if (!we && kn) check({tag, "_rdata"}, S_DAT_O, old);
      if (we && !oor) model_write(adr, dat, sel);
      @(negedge clk);
      check({tag, "_end_ack"}, 32'(S_ACK_O), 32'd0);
      check({tag, "_end_dat"}, S_DAT_O, 32'd0);
      idle_bus();
   endtask

   task automatic back_to_back();
      @(negedge clk);
      drive_req(1'b0, 32'h10, 32'h0, 4'hF);
      @(negedge clk);
      S_ADR_I = 32'h14;
      check("b2b_mem1_ack", 32'(S_ACK_O), 32'd0);
      @(negedge clk);
      check("b2b_ack1", 32'(S_ACK_O), 32'd1);
      check("b2b_dat1", S_DAT_O, model[4]);
      @(negedge clk);
      check("b2b_gap_ack", 32'(S_ACK_O), 32'd0);
      check("b2b_gap_dat", S_DAT_O, 32'd0);
      @(negedge clk);
      check("b2b_mem2_ack", 32'(S_ACK_O), 32'd0);
      S_STB_I = 1'b0;
      @(negedge clk);
      check("b2b_ack2", 32'(S_ACK_O), 32'd1);
      check("b2b_dat2", S_DAT_O, model[5]);
      @(negedge clk);
      check("b2b_end_ack", 32'(S_ACK_O), 32'd0);
      idle_bus();
   endtask

   task automatic abort_write(input logic [31:0] adr, input logic [31:0] dat);
      @(negedge clk);
      drive_req(1'b1, adr, dat, 4'hF);
      @(negedge clk);
      S_CYC_I = 1'b0;
      S_STB_I = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_ack", 32'(S_ACK_O), 32'd0);
         check("abort_err", 32'(S_ERR_O), 32'd0);
      end
      idle_bus();
   endtask

   // Reset during MEM (in_resp=0) or during RESP (in_resp=1).
   task automatic reset_mid(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input bit in_resp);
      @(negedge clk);
      drive_req(we, adr, dat, 4'hF);
      @(negedge clk);
      S_STB_I = 1'b0;
      if (in_resp) begin
         @(negedge clk);
         check("rst_pre_ack", 32'(S_ACK_O), 32'd1);
      end
      arst = 1'b0;
      #1;
      check("rst_ack", 32'(S_ACK_O), 32'd0);
      check("rst_err", 32'(S_ERR_O), 32'd0);
      check("rst_dat", S_DAT_O, 32'd0);
      idle_bus();
      repeat (2) @(negedge clk);
      check("rst_hold_ack", 32'(S_ACK_O), 32'd0);
      arst = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      arst = 1'b0;
      idle_bus();
      for (int i = 0; i < 256; i++) begin
         model[i] = 32'd0;
         known[i] = 1'b0;
      end
      #1;
      check("reset_ack", 32'(S_ACK_O), 32'd0);
      check("reset_err", 32'(S_ERR_O), 32'd0);
      check("reset_dat", S_DAT_O, 32'd0);
      repeat (3) @(negedge clk);
      arst    = 1'b1;
      started = 1'b1;

      xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "w10");
      xfer(1'b0, 32'h10, 32'h0, 4'h0, "r10");

      xfer(1'b1, 32'h20, 32'h1122_3344, 4'hF, "w20");
      xfer(1'b1, 32'h20, 32'hAA55_66BB, 4'b1001, "w20_sel");
      xfer(1'b0, 32'h22, 32'h0, 4'h1, "r20");

      xfer(1'b1, 32'h14, 32'h0BAD_F00D, 4'hF, "w14");
      back_to_back();

      xfer(1'b1, 32'h30, 32'h0, 4'hF, "w30_zero");
      abort_write(32'h30, 32'h5555_5555);
      xfer(1'b0, 32'h30, 32'h0, 4'hF, "r30");

      xfer(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, "w0");
      xfer(1'b1, 32'h400, 32'h0BAD_C0DE, 4'hF, "w400");
      xfer(1'b0, 32'h400, 32'h0, 4'hF, "r400");
      xfer(1'b0, 32'h0, 32'h0, 4'hF, "r0");

      xfer(1'b1, 32'h40, 32'hA5A5_5A5A, 4'hF, "w40");
      reset_mid(1'b1, 32'h40, 32'h1234_5678, 1'b0);
      xfer(1'b0, 32'h40, 32'h0, 4'hF, "r40_after_rst");
      reset_mid(1'b0, 32'h40, 32'h0, 1'b1);
      xfer(1'b0, 32'h40, 32'h0, 4'hF, "r40_after_rst2");

      for (int n = 0; n < 200; n++) begin
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 4) == 0) a[31:10] = 22'($urandom);
         xfer(1'($urandom), a, $urandom, 4'($urandom), "rnd");
      end

      repeat (2) @(negedge clk);
      started = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
